// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: matrix geometry,
// FSM state encoding and small row-decoding functions.
package keypad_scan_pkg;

    localparam int KEY_CODE_BIT_WIDTH = 4;
    localparam int KEY_ROW_NUM        = 4;
    localparam int KEY_COL_NUM        = 4;

    typedef enum logic [1:0] {
        KS_SCAN     = 2'd0,
        KS_DEBOUNCE = 2'd1,
        KS_HELD     = 2'd2
    } ks_state_e;

    // True when exactly one active-low row is asserted; ghosting patterns fail.
    function automatic logic single_low(input logic [KEY_ROW_NUM-1:0] rows_n);
        int unsigned lows;
        lows = 0;
        for (int i = 0; i < KEY_ROW_NUM; i++) begin
            if (!rows_n[i]) lows++;
        end
        return (lows == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [KEY_ROW_NUM-1:0] rows_n);
        logic [1:0] idx;
        idx = '0;
        for (int i = KEY_ROW_NUM - 1; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Active-low one-hot pattern, used both for column strobes and row matching.
    function automatic logic [3:0] strobe_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and key-event signals of the scanner, bundled for the top port.
interface keypad_scan_if;
    import keypad_scan_pkg::*;

    logic [KEY_ROW_NUM-1:0]        row_n;
    logic [KEY_COL_NUM-1:0]        col_n;
    logic [KEY_CODE_BIT_WIDTH-1:0] key_code;
    logic                          key_valid;
    logic                          key_held;

    // key_valid is a one-cycle strobe with no ready: the consumer must take
    // key_code in that cycle; key_code then stays put until the next accept.
    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones so
// idle pulled-up lines read as released.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes columns, debounces the synchronized row
// returns and reports accepted keys as a code with a valid strobe and held level.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 20000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp,
    output ks_state_e     state_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_CNT);

    logic [KEY_ROW_NUM-1:0] rows_s;

    keypad_sync #(.WIDTH(KEY_ROW_NUM)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (kp.row_n),
        .q_o (rows_s)
    );

    // Dwell counter free-runs in every state; its last count is the sample tick.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sample = (cnt_q == CNT_LAST);

    ks_state_e                     state_q;
    logic [1:0]                    col_idx_q;
    logic [1:0]                    row_idx_q;
    logic [DB_W-1:0]               match_q;
    logic [DB_W-1:0]               clear_q;
    logic [KEY_COL_NUM-1:0]        col_n_q;
    logic [KEY_CODE_BIT_WIDTH-1:0] key_code_q;
    logic                          key_valid_q;
    logic                          key_held_q;

    logic [1:0]      col_next;
    logic [DB_W-1:0] match_inc;
    logic [DB_W-1:0] clear_inc;

    assign col_next  = col_idx_q + 2'd1;
    assign match_inc = match_q + DB_W'(1);
    assign clear_inc = clear_q + DB_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= KS_SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            match_q     <= '0;
            clear_q     <= '0;
            col_n_q     <= 4'b1110;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (sample) begin
                case (state_q)
                    KS_SCAN: begin
                        if (single_low(rows_s)) begin
                            row_idx_q <= low_index(rows_s);
                            match_q   <= DB_W'(1);
                            state_q   <= KS_DEBOUNCE;
                        end else begin
                            col_idx_q <= col_next;
                            col_n_q   <= strobe_n(col_next);
                        end
                    end
                    KS_DEBOUNCE: begin
                        if (rows_s == strobe_n(row_idx_q)) begin
                            if (match_inc == DB_DONE) begin
                                key_code_q  <= {row_idx_q, col_idx_q};
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                clear_q     <= '0;
                                state_q     <= KS_HELD;
                            end else begin
                                match_q <= match_inc;
                            end
                        end else begin
                            col_idx_q <= col_next;
                            col_n_q   <= strobe_n(col_next);
                            state_q   <= KS_SCAN;
                        end
                    end
                    KS_HELD: begin
                        // Only the latched row matters; other keys are ignored.
                        if (rows_s[row_idx_q]) begin
                            if (clear_inc == DB_DONE) begin
                                key_held_q <= 1'b0;
                                clear_q    <= '0;
                                col_idx_q  <= col_next;
                                col_n_q    <= strobe_n(col_next);
                                state_q    <= KS_SCAN;
                            end else begin
                                clear_q <= clear_inc;
                            end
                        end else begin
                            clear_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= KS_SCAN;
                    end
                endcase
            end
        end
    end

    assign kp.col_n     = col_n_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a small keypad-matrix model driving the rows.
module tb_keypad_scan;
    import keypad_scan_pkg::*;

    localparam int SD = 4;
    localparam int DB = 3;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    ks_state_e state;

    keypad_scan_if kp();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk     (clk),
        .rst     (rst),
        .kp      (kp),
        .state_o (state)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is strobed.
    logic [15:0] pressed = '0;
    logic [3:0]  row_bits;

    always_comb begin
        row_bits = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp.col_n[c]) row_bits[r] = 1'b0;
            end
        end
    end

    assign kp.row_n = row_bits;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         cyc      = 0;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (kp.key_valid) begin
            n_valid++;
            check_eq("valid_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("key_code", 32'(kp.key_code), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic wait_valid(input int bound);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (!kp.key_valid && i < bound);
        check_eq("valid_seen", 32'(kp.key_valid), 1);
    endtask

    task automatic wait_state(input ks_state_e s, input int bound);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (state != s && i < bound);
        check_eq("state_reached", 32'(state), 32'(s));
    endtask

    task automatic wait_held_low(input int bound);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (kp.key_held && i < bound);
        check_eq("held_released", 32'(kp.key_held), 0);
    endtask

    logic [3:0] col_pat[4];
    int         t0;
    int         changes;
    int         non_scan;
    logic [3:0] prev_col;

    initial begin
        col_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset values while reset is held.
        repeat (3) step();
        check_eq("rst_col_n", 32'(kp.col_n), 32'(4'b1110));
        check_eq("rst_key_code", 32'(kp.key_code), 0);
        check_eq("rst_key_valid", 32'(kp.key_valid), 0);
        check_eq("rst_key_held", 32'(kp.key_held), 0);
        check_eq("rst_state", 32'(state), 32'(KS_SCAN));

        // Idle scan: each column held for SD cycles.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check_eq("idle_col_n", 32'(kp.col_n), 32'(col_pat[(k / SD) % 4]));
        end

        // Clean press of row 2, col 1.
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_state(KS_DEBOUNCE, 40);
        check_eq("press_col_frozen", 32'(kp.col_n), 32'(4'b1101));
        t0 = cyc;
        wait_valid(40);
        check_eq("press_to_valid", 32'(cyc - t0), 32'((DB - 1) * SD));
        check_eq("press_held", 32'(kp.key_held), 1);
        check_eq("press_state", 32'(state), 32'(KS_HELD));
        check_eq("press_col_n", 32'(kp.col_n), 32'(4'b1101));
        pressed[9] = 1'b0;
        t0 = cyc;
        wait_held_low(60);
        check_eq("release_time", 32'(cyc - t0), 32'(DB * SD));
        check_eq("release_col_n", 32'(kp.col_n), 32'(4'b1011));
        check_eq("release_code_kept", 32'(kp.key_code), 32'h9);
        check_eq("release_state", 32'(state), 32'(KS_SCAN));
        check_eq("press_valid_count", 32'(n_valid), 1);

        // Bounce: two matching samples, then the key lifts.
        pressed[9] = 1'b1;
        wait_state(KS_DEBOUNCE, 40);
        check_eq("bounce_col_n", 32'(kp.col_n), 32'(4'b1101));
        repeat (SD) step();
        check_eq("bounce_still_db", 32'(state), 32'(KS_DEBOUNCE));
        pressed[9] = 1'b0;
        wait_state(KS_SCAN, 20);
        check_eq("bounce_col_next", 32'(kp.col_n), 32'(4'b1011));
        check_eq("bounce_code_kept", 32'(kp.key_code), 32'h9);
        check_eq("bounce_held", 32'(kp.key_held), 0);
        check_eq("bounce_valid_count", 32'(n_valid), 1);

        // Ghost: rows 2 and 3 low on column 0.
        pressed[8]  = 1'b1;
        pressed[12] = 1'b1;
        changes  = 0;
        non_scan = 0;
        prev_col = kp.col_n;
        for (int k = 0; k < 8 * SD; k++) begin
            step();
            if (kp.col_n != prev_col) changes++;
            if (state != KS_SCAN) non_scan++;
            prev_col = kp.col_n;
        end
        check_eq("ghost_col_changes", 32'(changes), 8);
        check_eq("ghost_no_debounce", 32'(non_scan), 0);
        check_eq("ghost_valid_count", 32'(n_valid), 1);
        pressed[8]  = 1'b0;
        pressed[12] = 1'b0;

        // Release glitch: 2 clear, 1 pressed, 3 clear samples.
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid(80);
        pressed[9] = 1'b0;
        t0 = cyc;
        repeat (2 * SD) step();
        pressed[9] = 1'b1;
        repeat (SD) step();
        check_eq("glitch_held", 32'(kp.key_held), 1);
        pressed[9] = 1'b0;
        wait_held_low(60);
        check_eq("glitch_release_time", 32'(cyc - t0), 32'((DB + 3) * SD));
        check_eq("glitch_col_n", 32'(kp.col_n), 32'(4'b1011));
        check_eq("glitch_valid_count", 32'(n_valid), 2);

        // Reset mid-hold, with a second key pressed during the hold.
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid(80);
        pressed[0] = 1'b1;
        repeat (3 * SD) step();
        check_eq("hold_other_key_held", 32'(kp.key_held), 1);
        check_eq("hold_other_key_state", 32'(state), 32'(KS_HELD));
        check_eq("hold_other_key_valid", 32'(n_valid), 3);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_col_n", 32'(kp.col_n), 32'(4'b1110));
        check_eq("midrst_key_code", 32'(kp.key_code), 0);
        check_eq("midrst_key_valid", 32'(kp.key_valid), 0);
        check_eq("midrst_key_held", 32'(kp.key_held), 0);
        check_eq("midrst_state", 32'(state), 32'(KS_SCAN));
        pressed[9] = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        exp_q.push_back(4'h0);
        t0 = cyc;
        wait_valid(40);
        check_eq("postrst_press_time", 32'(cyc - t0), 32'(DB * SD));
        check_eq("postrst_held", 32'(kp.key_held), 1);
        repeat (2 * SD) step();
        check_eq("postrst_valid_count", 32'(n_valid), 4);
        check_eq("exp_q_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanning reader for a 4x4 matrix keypad; the input-side counterpart of the 14-segment display scan path. Strobes one keypad column at a time, synchronizes and debounces the row returns, and emits a 4-bit key code with a one-cycle valid strobe plus a held level. The key code feeds the time-setting logic and can drive the 14-segment decoder directly for hex display.

## Interface
- SCAN_DIV, 20000: clk cycles per column dwell (0.5 ms at 40 MHz); must be >= 4
- DEBOUNCE_CNT, 8: consecutive matching samples needed to accept a press, and consecutive clear samples needed to accept a release; must be >= 2
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- row_n  input  4  keypad rows, active-low, external pull-ups, asynchronous to clk
- col_n  output  4  column strobe, exactly one bit low at any time
- key_code  output  4  last accepted key, code = row*4 + col
- key_valid  output  1  one-cycle pulse when key_code updates
- key_held  output  1  high from acceptance until release is accepted

## Operation
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized value rows_s.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. A sample is taken on the cycle the count equals SCAN_DIV-1. The counter runs in every state.
- States: SCAN, DEBOUNCE, HELD.
- SCAN: col_n = ~(1 << col_idx). At a sample with no row low, col_idx increments mod 4 (3 wraps to 0). At a sample with exactly one row low, latch row_idx/col_idx, set match count to 1, and go to DEBOUNCE with col_idx frozen. At a sample with two or more rows low, treat as no key and advance.
- DEBOUNCE: each sample compares rows_s to the latched single row. On a match, increment the count. When the count reaches DEBOUNCE_CNT: key_code <= row_idx*4 + col_idx, key_valid pulses, key_held <= 1, and the state goes to HELD. On a mismatch (no row, a different row, or multiple rows low), there is no output change; col_idx advances and the state returns to SCAN.
- HELD: col_idx stays frozen. Each sample with the latched row high increments the clear count; any sample with the latched row low resets the clear count to 0. When the clear count reaches DEBOUNCE_CNT: key_held <= 0, col_idx advances, and the state returns to SCAN. Other keys pressed during HELD are ignored. key_code retains its value.
- No auto-repeat. One key_valid per accepted press.
- Reset values: col_n=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN, col_idx=0, all counters 0, synchronizer flops = 4'b1111.
- Reset takes effect immediately in any state, mid-debounce or mid-hold. Reset dominates any simultaneous sample event.

## Timing
- Input-to-rows_s latency: 2 cycles.
- All outputs are registered. col_n changes on the cycle after the sample that advances col_idx.
- key_valid is high for exactly one cycle: the cycle after the sample at which the match count reaches DEBOUNCE_CNT. key_held rises in the same cycle.
- Minimum press-to-valid time with a stable press already present on the scanned column: (DEBOUNCE_CNT-1)*SCAN_DIV + 1 cycles after the first detecting sample.
- Release-to-key_held-low time: the cycle after the DEBOUNCE_CNT-th consecutive clear sample.
- A full idle scan period is 4*SCAN_DIV cycles.

## Structure
- global.v gains `KEY_CODE_BIT_WIDTH (4), `KEY_ROW_NUM (4), `KEY_COL_NUM (4), and state encodings `KS_SCAN, `KS_DEBOUNCE, `KS_HELD.
- One sub-module: keypad_sync, a parameterized-width 2-flop synchronizer with asynchronous active-high reset to all-ones.
- The dwell counter, FSM, and output registers live in keypad_scan.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.
- Reset: assert rst mid-cycle -> col_n=1110 and key_code/key_valid/key_held=0 immediately. Release rst with row_n=1111 -> col_n steps 1110, 1101, 1011, 0111, 1110, each held for 4 cycles.
- Clean press: drive row_n=1011 whenever col_n=1101 (row 2, col 1), held stable -> col_n freezes at 1101, key_valid pulses once, key_code=4'h9, key_held=1. Release -> key_held=0 after 3 clear samples, then col_n advances to 1011.
- Bounce: the same key is low for only 2 samples, then high -> no key_valid, key_code unchanged, scan resumes at col_n=1011.
- Ghost/multi-row: row_n=0011 on column 0 -> no DEBOUNCE entry and no key_valid; scan continues.
- Release glitch: in HELD, release for 2 samples, re-press for 1 sample, then release for 3 samples -> key_held stays 1 until the final 3rd clear sample. There is no second key_valid.
- Reset mid-hold: rst pulsed while key_held=1 -> outputs return to their reset values at once. After rst is released with the key still pressed on column 0 (row_n=1110), a new press is accepted with key_code=4'h0 and one key_valid.
